// File: rtl/sr_latch_monitor.sv
// sr_latch_monitor: clocked checker for a NAND SR latch.
// Samples the active-low S/R inputs and the latch outputs Q/P and keeps its own
// model of the latch. After each input change it waits SETTLE cycles, then
// compares every cycle and counts compares and failures in saturating counters.
// Optional feature: define SR_MON_FORBID_CHECK_EN so that each entry into
// S=R=0 pulses FORBID and counts as an error.
module sr_latch_monitor #(
   parameter int unsigned SETTLE = 2,  // legal 1..15
   parameter int unsigned CNT_W  = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             S,
   input  logic             R,
   input  logic             Q,
   input  logic             P,
   output logic             EXP_Q,
   output logic             EXP_P,
   output logic             VALID,
   output logic             MISMATCH,
   output logic             FORBID,
   output logic [CNT_W-1:0] ERR_CNT,
   output logic [CNT_W-1:0] CHK_CNT
);

   localparam logic [3:0]       SettleLoad = 4'(SETTLE - 1);
   localparam logic [CNT_W-1:0] CntMax     = '1;
   localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

   typedef enum logic [1:0] {
      StUnknown,
      StSettle,
      StCheck
   } state_e;

   state_e           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             s_prev_q, r_prev_q;
   logic             exp_q_q, exp_q_d;
   logic             exp_p_q, exp_p_d;
   logic             valid_q, valid_d;
   logic             mismatch_q, mismatch_d;
   logic             forbid_q, forbid_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic [CNT_W-1:0] chk_q, chk_d;

   logic change;
   logic do_cmp;
   logic fail;
   logic forbid_entry;

   // Latch model: next expected outputs from the sampled S/R and previous sample.
   always_comb begin
      change  = ({S, R} != {s_prev_q, r_prev_q});
      exp_q_d = exp_q_q;
      exp_p_d = exp_p_q;
      valid_d = valid_q;
      case ({S, R})
         2'b01: begin
            exp_q_d = 1'b1;
            exp_p_d = 1'b0;
            valid_d = 1'b1;
         end
         2'b10: begin
            exp_q_d = 1'b0;
            exp_p_d = 1'b1;
            valid_d = 1'b1;
         end
         2'b00: begin
            exp_q_d = 1'b1;
            exp_p_d = 1'b1;
            valid_d = 1'b1;
         end
         default: begin
            // Release of both inputs straight out of 0,0 races; outcome unknown.
            if (!s_prev_q && !r_prev_q) begin
               exp_q_d = 1'b0;
               exp_p_d = 1'b0;
               valid_d = 1'b0;
            end
         end
      endcase
   end

   // Settle FSM: any change restarts the window; compare once it has elapsed.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      do_cmp  = 1'b0;
      if (change) begin
         if (valid_d) begin
            state_d = StSettle;
            cnt_d   = SettleLoad;
         end else begin
            state_d = StUnknown;
            cnt_d   = '0;
         end
      end else begin
         case (state_q)
            StSettle: begin
               if (cnt_q == 4'd0) begin
                  state_d = StCheck;
                  do_cmp  = 1'b1;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            StCheck: do_cmp = 1'b1;
            default: ;
         endcase
      end
   end

   // Compare result, forbidden-entry flag and saturating counters.
   always_comb begin
      fail       = do_cmp && ({Q, P} != {exp_q_q, exp_p_q});
      mismatch_d = fail;
`ifdef SR_MON_FORBID_CHECK_EN
      forbid_entry = change && !S && !R;
`else
      forbid_entry = 1'b0;
`endif
      forbid_d = forbid_entry;
      chk_d    = chk_q;
      err_d    = err_q;
      if (do_cmp && (chk_q != CntMax)) begin
         chk_d = chk_q + CntOne;
      end
      // A change and a compare never share an edge, so at most one increment.
      if ((fail || forbid_entry) && (err_q != CntMax)) begin
         err_d = err_q + CntOne;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= StUnknown;
         cnt_q      <= '0;
         s_prev_q   <= 1'b1;
         r_prev_q   <= 1'b1;
         exp_q_q    <= 1'b0;
         exp_p_q    <= 1'b0;
         valid_q    <= 1'b0;
         mismatch_q <= 1'b0;
         forbid_q   <= 1'b0;
         err_q      <= '0;
         chk_q      <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         s_prev_q   <= S;
         r_prev_q   <= R;
         exp_q_q    <= exp_q_d;
         exp_p_q    <= exp_p_d;
         valid_q    <= valid_d;
         mismatch_q <= mismatch_d;
         forbid_q   <= forbid_d;
         err_q      <= err_d;
         chk_q      <= chk_d;
      end
   end

   assign EXP_Q    = exp_q_q;
   assign EXP_P    = exp_p_q;
   assign VALID    = valid_q;
   assign MISMATCH = mismatch_q;
   assign FORBID   = forbid_q;
   assign ERR_CNT  = err_q;
   assign CHK_CNT  = chk_q;

endmodule
